// File: rtl/router_pkg.sv
// Shared types for the router destination-side reader: header field widths,
// reader FSM states and header field extraction helpers.
package router_pkg;
  localparam int PKT_LEN_W  = 6;
  localparam int PKT_ADDR_W = 2;

  typedef enum logic [1:0] {IDLE, HDR_RD, HDR_WAIT, BODY} rd_state_e;

  function automatic logic [PKT_LEN_W-1:0] pkt_hdr_len(input logic [7:0] hdr);
    return hdr[7:2];
  endfunction

  function automatic logic [PKT_ADDR_W-1:0] pkt_hdr_addr(input logic [7:0] hdr);
    return hdr[1:0];
  endfunction
endpackage

// File: rtl/rd_skid_fifo.sv
// Payload skid FIFO: synchronous, push/pop same cycle, zero-latency read of the head entry.
// No internal backpressure; the producer keeps it from overflowing using o_count.
module rd_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_pop_dat,
  output logic [CW-1:0] o_count,
  output logic          o_empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_dat = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
endmodule

// File: rtl/router_dst_reader.sv
// Drains one router output port: header, len payload bytes, parity; payload out as ready/valid.
// Read latency 1 cycle; reads are throttled by skid credit so out_ready low stops reads.
module router_dst_reader
  import router_pkg::*;
#(
  parameter int START_DLY  = 0,
  parameter int STALL_MAX  = 64,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid_out,
  input  logic [7:0]            i_data_out,
  output logic                  o_read_enb,
  output logic [7:0]            o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_out_last,
  output logic                  o_hdr_valid,
  output logic [PKT_LEN_W-1:0]  o_hdr_len,
  output logic [PKT_ADDR_W-1:0] o_hdr_addr,
  output logic                  o_pkt_done,
  output logic                  o_parity_err,
  output logic                  o_pkt_abort
);
  localparam int CW  = $clog2(SKID_DEPTH) + 1;
  localparam int WDW = $clog2(STALL_MAX + 1);

  rd_state_e             r_state;
  logic [4:0]            r_dly_cnt;
  logic                  r_inflight;
  logic [PKT_LEN_W:0]    r_rem_issue;
  logic [PKT_LEN_W:0]    r_rem_rx;
  logic [7:0]            r_acc;
  logic [WDW-1:0]        r_stall_cnt;
  logic                  r_hdr_valid;
  logic [PKT_LEN_W-1:0]  r_hdr_len;
  logic [PKT_ADDR_W-1:0] r_hdr_addr;
  logic                  r_pkt_done;
  logic                  r_parity_err;
  logic                  r_pkt_abort;

  logic          w_issue_ok;
  logic          w_credit_ok;
  logic          w_rd;
  logic          w_start;
  logic          w_push;
  logic [8:0]    w_push_dat;
  logic          w_pop;
  logic [8:0]    w_skid_dat;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_stall_fire;

  always_comb begin
    w_issue_ok   = (r_state == HDR_RD) || ((r_state == BODY) && (r_rem_issue != '0));
    // Bytes already queued plus the one still in the read pipe must leave room for one more.
    w_credit_ok  = ({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) <= (CW+1)'(SKID_DEPTH - 2);
    w_rd         = w_issue_ok && i_valid_out && w_credit_ok;
    w_start      = i_valid_out && (({1'b0, r_dly_cnt} + 6'd1) >= 6'(START_DLY));
    w_push       = (r_state == BODY) && r_inflight && (r_rem_rx != 7'd1);
    w_push_dat   = {(r_rem_rx == 7'd2), i_data_out};
    w_pop        = !w_empty && i_out_ready;
    w_stall_fire = ((r_state == HDR_WAIT) || (r_state == BODY)) && !r_inflight &&
                   (r_stall_cnt == WDW'(STALL_MAX - 1));
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_dly_cnt    <= '0;
      r_inflight   <= 1'b0;
      r_rem_issue  <= '0;
      r_rem_rx     <= '0;
      r_acc        <= '0;
      r_stall_cnt  <= '0;
      r_hdr_valid  <= 1'b0;
      r_hdr_len    <= '0;
      r_hdr_addr   <= '0;
      r_pkt_done   <= 1'b0;
      r_parity_err <= 1'b0;
      r_pkt_abort  <= 1'b0;
    end else begin
      r_inflight   <= w_rd;
      r_hdr_valid  <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_parity_err <= 1'b0;
      r_pkt_abort  <= 1'b0;

      if ((r_state == HDR_WAIT) || (r_state == BODY))
        r_stall_cnt <= r_inflight ? '0 : r_stall_cnt + 1'b1;
      else
        r_stall_cnt <= '0;

      case (r_state)
        IDLE: begin
          if (!i_valid_out) begin
            r_dly_cnt <= '0;
          end else if (w_start) begin
            r_dly_cnt <= '0;
            r_state   <= HDR_RD;
          end else if (r_dly_cnt != 5'h1f) begin
            r_dly_cnt <= r_dly_cnt + 1'b1;
          end
        end
        HDR_RD: begin
          if (w_rd) r_state <= HDR_WAIT;
        end
        HDR_WAIT: begin
          if (r_inflight) begin
            r_hdr_len   <= pkt_hdr_len(i_data_out);
            r_hdr_addr  <= pkt_hdr_addr(i_data_out);
            r_hdr_valid <= 1'b1;
            r_acc       <= i_data_out;
            r_rem_issue <= {1'b0, pkt_hdr_len(i_data_out)} + 7'd1;
            r_rem_rx    <= {1'b0, pkt_hdr_len(i_data_out)} + 7'd1;
            r_state     <= BODY;
          end
        end
        BODY: begin
          if (w_rd) r_rem_issue <= r_rem_issue - 1'b1;
          if (r_inflight) begin
            if (r_rem_rx == 7'd1) begin
              r_pkt_done   <= 1'b1;
              r_parity_err <= (r_acc != i_data_out);
              r_state      <= IDLE;
            end else begin
              r_acc    <= r_acc ^ i_data_out;
              r_rem_rx <= r_rem_rx - 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // Watchdog only fires with nothing in flight, so it never races a byte capture.
      if (w_stall_fire) begin
        r_pkt_done  <= 1'b1;
        r_pkt_abort <= 1'b1;
        r_state     <= IDLE;
        r_rem_issue <= '0;
        r_rem_rx    <= '0;
      end
    end
  end

  rd_skid_fifo #(.DEPTH(SKID_DEPTH), .W(9)) u_skid (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_pop_dat  (w_skid_dat),
    .o_count    (w_count),
    .o_empty    (w_empty)
  );

  assign o_read_enb   = w_rd;
  assign o_out_valid  = !w_empty;
  assign o_out_data   = w_skid_dat[7:0];
  assign o_out_last   = w_skid_dat[8];
  assign o_hdr_valid  = r_hdr_valid;
  assign o_hdr_len    = r_hdr_len;
  assign o_hdr_addr   = r_hdr_addr;
  assign o_pkt_done   = r_pkt_done;
  assign o_parity_err = r_parity_err;
  assign o_pkt_abort  = r_pkt_abort;
endmodule
